haar_wtu: RTL and testbench
===========================

// Module: haar_wtu
// PURPOSE
//   Downstream consumer of the WTU sample buffer. Once the buffer signals a full
//   frame, it drains all 2**DEPTH signed samples by driving the buffer read address.
//   It then runs a full-depth in-place Haar transform, one level per cycle.
//   Coefficients leave in Mallat order over a valid/ready stream to the next WTU stage.
// PARAMETERS
//   BITWIDTH  24           sample width (signed), must match the buffer
//   DEPTH     3            log2(frame length); frame = WIDTH = 2**DEPTH samples
//   OUT_WIDTH BITWIDTH+DEPTH  coefficient width (signed), 1 bit growth per level
// PORTS
//   clk        in   1          single clock, all state on posedge
//   rst        in   1          asynchronous reset, active-low (asserted when 0)
//   buf_ready  in   1          buffer has a full frame readable (buffer out_ready)
//   buf_addr   out  DEPTH      buffer read address (to buffer out_addr)
//   buf_data   in   BITWIDTH   buffer read data, combinational from buf_addr
//   coef_valid out  1          coef_data/coef_idx/coef_last valid
//   coef_ready in   1          downstream accepts; transfer = valid & ready
//   coef_data  out  OUT_WIDTH  signed coefficient
//   coef_idx   out  DEPTH      Mallat index of coef_data (0..WIDTH-1)
//   coef_last  out  1          high with idx WIDTH-1
//   busy       out  1          high in any state other than IDLE
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, buf_addr=0, coef_valid=0, coef_data=0,
//     coef_idx=0, coef_last=0, busy=0, all working registers cleared.
//   - States: IDLE -> FETCH -> COMP -> OUT -> IDLE.
//   - IDLE: buf_addr=0. On buf_ready=1, go to FETCH. No sample is captured in this cycle.
//   - FETCH: each cycle with buf_ready=1, capture x[buf_addr]<=buf_data, buf_addr+1.
//     A cycle with buf_ready=0 holds buf_addr and captures nothing.
//     Capture at buf_addr=WIDTH-1 -> COMP, buf_addr wraps to 0.
//     With buf_ready held high, FETCH lasts exactly WIDTH cycles.
//     Every address 0..WIDTH-1 is presented once, so the buffer returns to IDLE.
//   - COMP: DEPTH cycles, level L=1..DEPTH, over the low WIDTH>>(L-1) working entries.
//     For each pair k: a=w[2k], b=w[2k+1]; s=a+b, d=a-b.
//     s goes to w[k]; d goes to w[(WIDTH>>L)+k].
//     All math is signed, sign-extended to OUT_WIDTH, with no overflow possible.
//   - After the last level -> OUT, coef_valid=1 on the next cycle.
//     Latency: first buf_ready cycle to first coef_valid = WIDTH+DEPTH+1 cycles,
//     or 12 at the defaults.
//   - OUT: coef_data=w[coef_idx]. Order is s_D, d_D, d_(D-1)[0..1] ... d_1[0..WIDTH/2-1].
//     On a transfer, coef_idx advances. The transfer at idx WIDTH-1 (coef_last=1)
//     -> IDLE with coef_valid=0.
//     While valid & !ready, data/idx/last are held stable. Valid never drops before transfer.
//   - buf_ready is ignored outside IDLE/FETCH, so the next frame waits until IDLE.
//   - Reset mid-operation aborts the frame with no partial output.
//     A buffer left mid-READ is recovered by the shared reset.
//   - Illegal state encodings -> IDLE with outputs at reset values.
// CONFIGURATION
//   WTU_AVG_EN defined: each level computes s=(a+b)>>>1 and d=(a-b)>>>1
//     (arithmetic shift, floor). Results stay in BITWIDTH+1 bits and are
//     sign-extended onto coef_data. Port widths are unchanged.
//   WTU_AVG_EN undefined: unnormalised sums and differences as above.
//   Timing and handshake are identical in both builds.
// TESTING
//   1. Frame 1,2,3,4,5,6,7,8, buf_ready held, coef_ready=1 -> coefficients
//      36,-16,-4,-4,-1,-1,-1,-1, idx 0..7, last on idx 7.
//      First valid 12 cycles after buf_ready.
//   2. Same frame with WTU_AVG_EN -> 4,-2,-1,-1,-1,-1,-1,-1.
//   3. All samples -8388608 (min 24-bit) -> coef 0 = -67108864, remaining 7 = 0,
//      with no wrap in 27 bits.
//   4. coef_ready toggled 1010..., plus a 5-cycle stall at idx 3 -> data/idx stable
//      during stalls, 8 transfers exactly, then busy=0.
//   5. buf_ready dropped for 2 cycles after addr 4 -> buf_addr holds at 5, capture resumes.
//      Output equals the no-gap result, and the buffer ends in IDLE.
//   6. rst=0 asserted in OUT at idx 2 -> coef_valid=0, busy=0, buf_addr=0 immediately.
//      The next full frame then produces correct results.

Source files
------------

// File: rtl/haar_wtu.sv
// haar_wtu: drains one frame of 2**DEPTH signed samples from the WTU sample buffer.
// It runs a full-depth in-place Haar transform, one level per cycle, and then streams
// the coefficients in Mallat order over a valid/ready interface.
// Build option: define WTU_AVG_EN for the averaging (halved) Haar variant.

module haar_wtu #(
   parameter int unsigned BITWIDTH  = 24,
   parameter int unsigned DEPTH     = 3,
   parameter int unsigned OUT_WIDTH = BITWIDTH + DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        buf_ready,
   output logic [DEPTH-1:0]            buf_addr,
   input  logic signed [BITWIDTH-1:0]  buf_data,
   output logic                        coef_valid,
   input  logic                        coef_ready,
   output logic signed [OUT_WIDTH-1:0] coef_data,
   output logic [DEPTH-1:0]            coef_idx,
   output logic                        coef_last,
   output logic                        busy
);

   localparam int WIDTH = 1 << DEPTH;
   localparam int LVL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StFetch, StComp, StOut} state_e;

   state_e                      state_q, state_d;
   logic [DEPTH-1:0]            addr_q;
   logic [DEPTH-1:0]            idx_q;
   logic [LVL_W-1:0]            lvl_q;
   logic signed [OUT_WIDTH-1:0] w_q [WIDTH];
   logic signed [OUT_WIDTH-1:0] w_d [WIDTH];
   logic                        last_lvl;
   logic                        last_cap;
   logic                        last_idx;

   assign last_lvl = (lvl_q == LVL_W'(DEPTH - 1));
   assign last_cap = (addr_q == DEPTH'(WIDTH - 1));
   assign last_idx = (idx_q == DEPTH'(WIDTH - 1));

   assign buf_addr = addr_q;
   assign coef_idx = idx_q;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (buf_ready) state_d = StFetch;
         StFetch: if (buf_ready && last_cap) state_d = StComp;
         StComp:  if (last_lvl) state_d = StOut;
         StOut:   if (coef_ready && last_idx) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the current state; coefficient data is forced to 0 unless valid
   always_comb begin
      busy       = 1'b0;
      coef_valid = 1'b0;
      coef_data  = '0;
      coef_last  = 1'b0;
      case (state_q)
         StFetch: busy = 1'b1;
         StComp:  busy = 1'b1;
         StOut: begin
            busy       = 1'b1;
            coef_valid = 1'b1;
            coef_data  = w_q[idx_q];
            coef_last  = last_idx;
         end
         default: ;
      endcase
   end

   // One Haar level: pairs in the low (WIDTH >> lvl) entries give sums (to the front)
   // and differences (to the upper half of that span); everything above is untouched.
   always_comb begin
      w_d = w_q;
      for (int l = 0; l < int'(DEPTH); l++) begin
         if (lvl_q == LVL_W'(l)) begin
            for (int k = 0; k < (WIDTH >> (l + 1)); k++) begin
`ifdef WTU_AVG_EN
               w_d[k]                     = (w_q[2*k] + w_q[2*k+1]) >>> 1;
               w_d[(WIDTH >> (l + 1)) + k] = (w_q[2*k] - w_q[2*k+1]) >>> 1;
`else
               w_d[k]                     = w_q[2*k] + w_q[2*k+1];
               w_d[(WIDTH >> (l + 1)) + k] = w_q[2*k] - w_q[2*k+1];
`endif
            end
         end
      end
   end

   // Datapath: sample capture, level counter, working array and output index
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= '0;
         idx_q  <= '0;
         lvl_q  <= '0;
         for (int i = 0; i < WIDTH; i++) w_q[i] <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               addr_q <= '0;
               idx_q  <= '0;
               lvl_q  <= '0;
            end
            StFetch: begin
               if (buf_ready) begin
                  w_q[addr_q] <= {{(OUT_WIDTH - BITWIDTH){buf_data[BITWIDTH-1]}}, buf_data};
                  // Wraps to 0 after the last address, leaving the buffer back at IDLE
                  addr_q      <= addr_q + DEPTH'(1);
               end
            end
            StComp: begin
               w_q   <= w_d;
               lvl_q <= last_lvl ? '0 : lvl_q + LVL_W'(1);
            end
            StOut: begin
               // Valid is always high here, so ready alone marks a transfer
               if (coef_ready) idx_q <= idx_q + DEPTH'(1);
            end
            default: begin
               addr_q <= '0;
               idx_q  <= '0;
               lvl_q  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_haar_wtu.sv
// Scoreboard bench for haar_wtu: expected coefficients are queued when a frame is
// loaded and compared as each valid/ready transfer happens.

module tb_haar_wtu;

   localparam int BW    = 24;
   localparam int DEPTH = 3;
   localparam int WIDTH = 8;
   localparam int OW    = BW + DEPTH;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 buf_ready = 1'b0;
   logic                 coef_ready = 1'b0;
   logic [DEPTH-1:0]     buf_addr;
   logic [DEPTH-1:0]     coef_idx;
   logic signed [BW-1:0] buf_data;
   logic                 coef_valid;
   logic                 coef_last;
   logic                 busy;
   logic signed [OW-1:0] coef_data;

   logic signed [BW-1:0] mem [WIDTH];
   assign buf_data = mem[buf_addr];

   always #5 clk = ~clk;

   haar_wtu #(
      .BITWIDTH  (BW),
      .DEPTH     (DEPTH),
      .OUT_WIDTH (OW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .buf_ready  (buf_ready),
      .buf_addr   (buf_addr),
      .buf_data   (buf_data),
      .coef_valid (coef_valid),
      .coef_ready (coef_ready),
      .coef_data  (coef_data),
      .coef_idx   (coef_idx),
      .coef_last  (coef_last),
      .busy       (busy)
   );

   typedef struct {
      longint data;
      int     idx;
      bit     last;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   xfers   = 0;
   int   lat;
   int   stall;
   int   tgl;

`ifdef WTU_AVG_EN
   longint t1_exp [WIDTH] = '{4, -2, -1, -1, -1, -1, -1, -1};
`else
   longint t1_exp [WIDTH] = '{36, -16, -4, -4, -1, -1, -1, -1};
`endif

   task automatic check(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Independent Haar model: repeated pairwise sum/difference on a shrinking prefix
   task automatic push_model();
      longint a [WIDTH];
      longint c [WIDTH];
      longint t [WIDTH];
      longint s, d;
      int     n;
      for (int i = 0; i < WIDTH; i++) a[i] = longint'(mem[i]);
      n = WIDTH;
      while (n > 1) begin
         for (int k = 0; k < n / 2; k++) begin
            s = a[2*k] + a[2*k+1];
            d = a[2*k] - a[2*k+1];
`ifdef WTU_AVG_EN
            s = s >>> 1;
            d = d >>> 1;
`endif
            t[k]       = s;
            c[n/2 + k] = d;
         end
         for (int k = 0; k < n / 2; k++) a[k] = t[k];
         n = n / 2;
      end
      c[0] = a[0];
      for (int i = 0; i < WIDTH; i++) sb.push_back('{data: c[i], idx: i, last: (i == WIDTH - 1)});
   endtask

   task automatic push_const();
      for (int i = 0; i < WIDTH; i++)
         sb.push_back('{data: t1_exp[i], idx: i, last: (i == WIDTH - 1)});
   endtask

   // Raise buf_ready until the first coefficient is valid; optional 2-cycle gap at addr 5
   task automatic run_frame(input bit gap, output int cycles);
      bit gapped;
      gapped    = 1'b0;
      cycles    = 0;
      buf_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         cycles++;
         if (gap && !gapped && buf_addr == 3'd5) begin
            gapped    = 1'b1;
            buf_ready = 1'b0;
            repeat (2) begin
               @(posedge clk); #1;
               cycles++;
               check("gap_addr_hold", buf_addr, 5);
            end
            buf_ready = 1'b1;
         end
         if (coef_valid) break;
      end
      buf_ready = 1'b0;
      check("valid_seen", coef_valid, 1);
   endtask

   task automatic finish_frame();
      for (int c = 0; c < 100; c++) begin
         if (!busy) break;
         @(posedge clk); #1;
      end
      check("end_busy", busy, 0);
      check("end_valid", coef_valid, 0);
      check("end_addr", buf_addr, 0);
      check("end_xfers", xfers, WIDTH);
      check("end_sb_empty", sb.size(), 0);
      xfers = 0;
   endtask

   // Monitor: score transfers and verify stability across stalls
   initial begin
      bit     stall_prev;
      longint held_data;
      int     held_idx;
      exp_t   e;
      stall_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && stall_prev) begin
            check("stall_valid", coef_valid, 1);
            check("stall_data", coef_data, held_data);
            check("stall_idx", coef_idx, held_idx);
         end
         stall_prev = rst && coef_valid && !coef_ready;
         held_data  = coef_data;
         held_idx   = coef_idx;
         if (rst && coef_valid && coef_ready) begin
            xfers++;
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("coef_data", coef_data, e.data);
               check("coef_idx", coef_idx, e.idx);
               check("coef_last", coef_last, e.last);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < WIDTH; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_valid", coef_valid, 0);
      check("rst_addr", buf_addr, 0);
      check("rst_data", coef_data, 0);
      check("rst_idx", coef_idx, 0);
      check("rst_last", coef_last, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Ramp 1..8, always ready
      for (int i = 0; i < WIDTH; i++) mem[i] = BW'(i + 1);
      push_const();
      coef_ready = 1'b1;
      run_frame(1'b0, lat);
      check("t1_latency", lat, 12);
      finish_frame();

      // Most negative samples: no wrap in the widened sum
      for (int i = 0; i < WIDTH; i++) mem[i] = 24'sh800000;
      push_model();
      run_frame(1'b0, lat);
      check("t3_latency", lat, 12);
      finish_frame();

      // Random frame, toggling ready with a 5-cycle stall at idx 3
      for (int i = 0; i < WIDTH; i++) mem[i] = BW'($urandom);
      push_model();
      coef_ready = 1'b0;
      run_frame(1'b0, lat);
      stall = 0;
      tgl   = 0;
      for (int c = 0; c < 200; c++) begin
         if (!busy) break;
         if (coef_idx == 3'd3 && stall < 5) begin
            coef_ready = 1'b0;
            stall++;
         end else begin
            coef_ready = (tgl % 2 == 0);
            tgl++;
         end
         @(posedge clk); #1;
      end
      coef_ready = 1'b1;
      finish_frame();

      // Ramp with a buf_ready gap after address 4
      for (int i = 0; i < WIDTH; i++) mem[i] = BW'(i + 1);
      push_const();
      run_frame(1'b1, lat);
      check("t5_latency", lat, 14);
      finish_frame();

      // Reset in OUT at idx 2 aborts the frame
      for (int i = 0; i < WIDTH; i++) mem[i] = BW'($urandom);
      push_model();
      run_frame(1'b0, lat);
      for (int c = 0; c < 10; c++) begin
         if (coef_idx == 3'd2) break;
         @(posedge clk); #1;
      end
      check("t6_at_idx2", coef_idx, 2);
      #1 rst = 1'b0;
      #1;
      check("t6_rst_valid", coef_valid, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_addr", buf_addr, 0);
      check("t6_rst_idx", coef_idx, 0);
      sb.delete();
      xfers = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < WIDTH; i++) mem[i] = BW'($urandom);
      push_model();
      run_frame(1'b0, lat);
      check("t6_latency", lat, 12);
      finish_frame();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
